// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-coded pulse link: FSM encoding,
// default timing parameters and the per-window edge counter width.
package freq_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } rx_state_e;

    localparam int BIT_CYCLES_DEF     = 1000;
    localparam int EDGE_THRESHOLD_DEF = 6;
    localparam int IDLE_CYCLES_DEF    = 2000;
    localparam int EDGE_CNT_W         = 4;

endpackage

// File: rtl/freq_shift_receiver_if.sv
// Receiver-side bundle: enable and pulse line in, decoded byte and status out.
interface freq_shift_receiver_if;
    logic       enable;
    logic       pulse_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output enable, pulse_in,
        input  data_out, data_valid, frame_error, busy
    );

    modport slave (
        input  enable, pulse_in,
        output data_out, data_valid, frame_error, busy
    );
endinterface

// File: rtl/pulse_edge_sync.sv
// Two-flop synchroniser for the asynchronous pulse line followed by a
// registered rising-edge detector (edge_det is high for one cycle).
module pulse_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic edge_det
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = pulse_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_det = edge_q;

endmodule

// File: rtl/freq_shift_receiver.sv
// Frequency-coded pulse receiver: counts rising edges per fixed bit window,
// frames 8 bits MSB first after an idle gap and flags carrier loss.
module freq_shift_receiver
    import freq_pkg::*;
#(
    parameter int BIT_CYCLES     = BIT_CYCLES_DEF,
    parameter int EDGE_THRESHOLD = EDGE_THRESHOLD_DEF,
    parameter int IDLE_CYCLES    = IDLE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    freq_shift_receiver_if.slave  rx
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WIN_W  = $clog2(BIT_CYCLES);

    localparam logic [IDLE_W-1:0]     IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(BIT_CYCLES - 1);
    localparam logic [EDGE_CNT_W-1:0] THRESH   = EDGE_CNT_W'(EDGE_THRESHOLD);

    function automatic logic [EDGE_CNT_W-1:0] sat_inc(
        input logic [EDGE_CNT_W-1:0] v,
        input logic                  inc
    );
        if (inc && (v != '1)) return v + EDGE_CNT_W'(1);
        return v;
    endfunction

    logic edge_det;

    pulse_edge_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (rx.pulse_in),
        .edge_det (edge_det)
    );

    rx_state_e             state_q,       state_d;
    logic [IDLE_W-1:0]     idle_cnt_q,    idle_cnt_d;
    logic [WIN_W-1:0]      win_cnt_q,     win_cnt_d;
    logic [EDGE_CNT_W-1:0] edge_cnt_q,    edge_cnt_d;
    logic [2:0]            bit_cnt_q,     bit_cnt_d;
    logic [6:0]            shreg_q,       shreg_d;
    logic [7:0]            data_out_q,    data_out_d;
    logic                  data_valid_q,  data_valid_d;
    logic                  frame_error_q, frame_error_d;

    logic [EDGE_CNT_W-1:0] total;
    logic                  rx_bit;

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        win_cnt_d     = win_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        // An edge on the window's last cycle still belongs to that window.
        total         = sat_inc(edge_cnt_q, edge_det);
        rx_bit        = (total >= THRESH);

        if (!rx.enable) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (edge_det) begin
                        if (idle_cnt_q == IDLE_MAX) begin
                            state_d    = ST_RECEIVE;
                            win_cnt_d  = '0;
                            bit_cnt_d  = '0;
                            edge_cnt_d = EDGE_CNT_W'(1);
                        end else begin
                            idle_cnt_d = '0;
                        end
                    end else if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                ST_RECEIVE: begin
                    if (win_cnt_q == WIN_LAST) begin
                        if (total == '0) begin
                            frame_error_d = 1'b1;
                            state_d       = ST_IDLE;
                            idle_cnt_d    = '0;
                        end else begin
                            shreg_d    = {shreg_q[5:0], rx_bit};
                            edge_cnt_d = '0;
                            win_cnt_d  = '0;
                            if (bit_cnt_q == 3'd7) begin
                                data_out_d   = {shreg_q, rx_bit};
                                data_valid_d = 1'b1;
                                state_d      = ST_IDLE;
                                idle_cnt_d   = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end else begin
                        win_cnt_d  = win_cnt_q + WIN_W'(1);
                        edge_cnt_d = total;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idle_cnt_q    <= '0;
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            win_cnt_q     <= win_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx.data_out    = data_out_q;
    assign rx.data_valid  = data_valid_q;
    assign rx.frame_error = frame_error_q;
    assign rx.busy        = (state_q == ST_RECEIVE);

endmodule
